fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
- Shares the write port of one synchronous FIFO (data_size/depth FIFO with writeEN/DIN/full) between N_REQ producers.
- Round-robin arbitration with bounded bursts: the owner may write up to MAX_BURST words before it must release the port.
- Sits directly in front of the FIFO. Drives its writeEN and DIN, and observes its full flag.

Parameters:
- N_REQ, 4, number of requesters (>=2)
- DATA_W, 8, word width; must equal the FIFO data_size
- MAX_BURST, 4, maximum accepted words per grant (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- req  in  N_REQ  per-requester "word available"; must stay high with stable data until acked
- din  in  N_REQ*DATA_W  requester data, flattened; requester i uses bits [i*DATA_W +: DATA_W]
- ack  out  N_REQ  one-hot; high in the cycle requester i's word is written
- fifo_full  in  1  FIFO full flag
- fifo_wr_en  out  1  to FIFO writeEN
- fifo_din  out  DATA_W  to FIFO DIN
- grant_valid  out  1  a requester currently owns the port
- grant_id  out  max(1,$clog2(N_REQ))  index of the owner; 0 when not valid

Behaviour:
- State machine has two states: IDLE and OWN.
- Registers:
  - state
  - owner
  - last_owner (reset value N_REQ-1, so requester 0 wins first)
  - beat_cnt, width $clog2(MAX_BURST+1)
- IDLE:
  - If req != 0: owner <= first set bit of req, searching from last_owner+1 upward with wrap; beat_cnt <= 0; state <= OWN.
  - Arbitration latency is 1 cycle. No writes occur in IDLE.
- OWN:
  - fifo_wr_en = req[owner] & ~fifo_full (combinational).
  - fifo_din = din slice of owner, whenever state==OWN; 0 in IDLE.
  - ack = onehot(owner) & fifo_wr_en. Transfer semantics are req&ack, the same edge on which the FIFO stores the word.
  - On each accepted word, beat_cnt increments.
- Release, from OWN to IDLE with last_owner <= owner:
  - (a) when an accepted word makes beat_cnt reach MAX_BURST; or
  - (b) req[owner]==0 in a cycle. No write occurs that cycle.
  - There is always one IDLE cycle between grants, including back-to-back grants to the same requester.
- fifo_full high while in OWN:
  - Stall: no wr_en, no ack, beat_cnt holds.
  - The owner keeps the grant; full alone never releases.
- Requests from non-owners are ignored until the next IDLE evaluation. Their din is never forwarded.
- grant_valid = (state==OWN). grant_id = owner when valid, else 0.
- Reset, including mid-burst:
  - state=IDLE, owner=0, beat_cnt=0, last_owner=N_REQ-1.
  - All outputs 0 in the cycle after the reset edge.
  - A partially completed burst is abandoned. Words already acked stay in the FIFO; the FIFO's own rst governs its content.
- Never more than one ack bit set. fifo_wr_en==|ack always.
- Never asserts wr_en while fifo_full. FIFO overflow is impossible by construction.

Decomposition:
- Package fifo_arb_pkg holds:
  - the state encoding (IDLE=0, OWN=1)
  - the localparam ID_W=max(1,$clog2(N_REQ))
  - the localparam CNT_W=$clog2(MAX_BURST+1)
- Sub-module rr_picker (combinational): inputs req[N_REQ] and last[ID_W]. Outputs found and idx, the first set bit after last with wrap. It is instantiated once and verified standalone.

Test Plan:
- Single requester, 6 words: req=4'b0010 held, fifo_full=0, MAX_BURST=4.
  - Expect grant_id=1 from cycle 1 and ack[1] on cycles 1-4.
  - Then IDLE on cycle 5, regrant on cycle 6, ack on cycles 6-7.
  - The FIFO receives all 6 words in order.
- All requesters saturating: req=4'b1111 continuous.
  - Grant order 0,1,2,3,0.
  - Each grant gives exactly 4 acks separated by 1 IDLE cycle: 16 words per 20 cycles.
- Full stall: fifo_full=1 for 3 cycles after the owner's 2nd beat.
  - fifo_wr_en=0 and ack=0 for those 3 cycles; grant is retained.
  - Beats 3-4 complete after full drops, then release.
- Early release: requester 2 drops req after 2 acks while requester 3 is requesting.
  - Requester 2 is released with beat_cnt=2.
  - IDLE for 1 cycle, then grant_id=3.
- Reset mid-burst: rst pulsed during requester 1's 3rd beat with req=4'b1111.
  - All outputs 0 the next cycle.
  - The first subsequent grant goes to requester 0.
- Full at grant: fifo_full=1 before requester 0 is granted.
  - grant_valid=1, no writes.
  - Writes begin the cycle fifo_full drops, with din slice 0 on fifo_din.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// The default widths match the arbiter's default parameters.
package fifo_arb_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } arb_state_t;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_width(input int m);
      return $clog2(m + 1);
   endfunction

   localparam int N_REQ_DEF     = 4;
   localparam int MAX_BURST_DEF = 4;
   localparam int ID_W          = id_width(N_REQ_DEF);
   localparam int CNT_W         = cnt_width(MAX_BURST_DEF);

endpackage

// File: rtl/fifo_write_arbiter_rr_picker.sv
// Round-robin picker: finds the first set request after 'last', wrapping around.
// The search starts at last+1, so 'last' itself is only chosen when it is the sole requester.
module rr_picker
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   localparam int IDX_W = id_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   // Scan offsets 1..N_REQ; the first hit latches and later hits are masked.
   always_comb begin
      found = 1'b0;
      idx   = {IDX_W{1'b0}};
      for (int k = 1; k <= N_REQ; k++) begin
         logic [IDX_W-1:0] cand;
         logic             hit;
         cand  = IDX_W'((int'(last) + k) % N_REQ);
         hit   = ~found & req[cand];
         idx   = hit ? cand : idx;
         found = found | hit;
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares one FIFO write port among N_REQ producers with round-robin grants and
// bounded bursts; a grant always ends with one IDLE cycle before the next pick.
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4,
   localparam int GID_W    = id_width(N_REQ),
   localparam int BEAT_W   = cnt_width(MAX_BURST)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*DATA_W-1:0]   din,
   output logic [N_REQ-1:0]          ack,
   input  logic                      fifo_full,
   output logic                      fifo_wr_en,
   output logic [DATA_W-1:0]         fifo_din,
   output logic                      grant_valid,
   output logic [GID_W-1:0]          grant_id
);

   arb_state_t        state_r, state_n;
   logic [GID_W-1:0]  owner_r, owner_n;
   logic [GID_W-1:0]  last_owner_r, last_owner_n;
   logic [BEAT_W-1:0] beat_cnt_r, beat_cnt_n;

   logic              pick_found;
   logic [GID_W-1:0]  pick_idx;
   logic              owner_req;
   logic              wr_en;
   logic [DATA_W-1:0] owner_data;

   rr_picker #(
      .N_REQ (N_REQ)
   ) u_picker (
      .req   (req),
      .last  (last_owner_r),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Owner request, write qualification and data/ack steering.
   always_comb begin
      owner_req  = req[owner_r];
      wr_en      = (state_r == ST_OWN) & owner_req & ~fifo_full;
      owner_data = {DATA_W{1'b0}};
      ack        = {N_REQ{1'b0}};
      for (int i = 0; i < N_REQ; i++) begin
         owner_data = (owner_r == GID_W'(i)) ? din[i*DATA_W +: DATA_W] : owner_data;
         ack[i]     = wr_en & (owner_r == GID_W'(i));
      end
      fifo_wr_en  = wr_en;
      fifo_din    = (state_r == ST_OWN) ? owner_data : {DATA_W{1'b0}};
      grant_valid = (state_r == ST_OWN);
      grant_id    = (state_r == ST_OWN) ? owner_r : {GID_W{1'b0}};
   end

   // Next-state: pick in IDLE; in OWN release on dropped request or a full burst.
   always_comb begin
      state_n      = state_r;
      owner_n      = owner_r;
      last_owner_n = last_owner_r;
      beat_cnt_n   = beat_cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (pick_found) begin
               owner_n    = pick_idx;
               beat_cnt_n = {BEAT_W{1'b0}};
               state_n    = ST_OWN;
            end else begin
               state_n    = ST_IDLE;
            end
         end
         ST_OWN: begin
            if (!owner_req) begin
               state_n      = ST_IDLE;
               last_owner_n = owner_r;
            end else if (wr_en) begin
               beat_cnt_n = beat_cnt_r + BEAT_W'(1);
               if (beat_cnt_r == BEAT_W'(MAX_BURST - 1)) begin
                  state_n      = ST_IDLE;
                  last_owner_n = owner_r;
               end else begin
                  state_n      = ST_OWN;
               end
            end else begin
               // Full stall: hold the grant and the beat count.
               state_n = ST_OWN;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // State registers; reset abandons any burst in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         owner_r      <= {GID_W{1'b0}};
         last_owner_r <= GID_W'(N_REQ - 1);
         beat_cnt_r   <= {BEAT_W{1'b0}};
      end else begin
         state_r      <= state_n;
         owner_r      <= owner_n;
         last_owner_r <= last_owner_n;
         beat_cnt_r   <= beat_cnt_n;
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter with per-cycle expectations and a
// FIFO model that records every accepted word.
module tb_fifo_write_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;

   logic            clk;
   logic            rst;
   logic [N-1:0]    req;
   logic [N*DW-1:0] din;
   logic [N-1:0]    ack;
   logic            fifo_full;
   logic            fifo_wr_en;
   logic [DW-1:0]   fifo_din;
   logic            grant_valid;
   logic [1:0]      grant_id;

   int total;
   int bad;
   logic [DW-1:0] fq[$];

   fifo_write_arbiter #(
      .N_REQ     (N),
      .DATA_W    (DW),
      .MAX_BURST (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .din         (din),
      .ack         (ack),
      .fifo_full   (fifo_full),
      .fifo_wr_en  (fifo_wr_en),
      .fifo_din    (fifo_din),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (fifo_wr_en && !rst) fq.push_back(fifo_din);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input int c, input logic v,
                            input logic [1:0] id, input logic [3:0] a,
                            input logic [7:0] d);
      chk($sformatf("%s.c%0d.valid", tag, c), 32'(grant_valid), 32'(v));
      chk($sformatf("%s.c%0d.id", tag, c), 32'(grant_id), 32'(id));
      chk($sformatf("%s.c%0d.ack", tag, c), 32'(ack), 32'(a));
      chk($sformatf("%s.c%0d.wr_en", tag, c), 32'(fifo_wr_en), 32'(|a));
      chk($sformatf("%s.c%0d.nofull", tag, c), 32'(fifo_wr_en & fifo_full), 32'd0);
      if (a != 4'b0000) chk($sformatf("%s.c%0d.din", tag, c), 32'(fifo_din), 32'(d));
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req       = 4'b0000;
      din       = 32'h0;
      fifo_full = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
      fq.delete();
   endtask

   initial begin
      int sent;
      int sent2;
      total = 0;
      bad   = 0;

      // Reset state
      do_reset();
      #1;
      check_out("reset", 0, 1'b0, 2'd0, 4'b0000, 8'h00);
      chk("reset.din", 32'(fifo_din), 32'd0);

      // Single requester, six words: burst of 4, idle, regrant for 2
      sent = 0;
      for (int c = 0; c < 10; c++) begin
         logic ea, ev;
         ea = (c >= 1 && c <= 4) || c == 6 || c == 7;
         ev = (c >= 1 && c <= 4) || (c >= 6 && c <= 8);
         req = (sent < 6) ? 4'b0010 : 4'b0000;
         din[15:8] = 8'h10 + 8'(sent);
         #1;
         check_out("single", c, ev, ev ? 2'd1 : 2'd0, ea ? 4'b0010 : 4'b0000, 8'h10 + 8'(sent));
         if (ea) sent++;
         cyc();
      end
      chk("single.count", 32'(fq.size()), 32'd6);
      for (int k = 0; k < 6 && k < fq.size(); k++)
         chk($sformatf("single.word%0d", k), 32'(fq[k]), 32'(8'h10 + 8'(k)));

      // All requesters saturating: grants 0,1,2,3,0, four beats each
      do_reset();
      req = 4'b1111;
      din = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      for (int c = 0; c < 22; c++) begin
         logic       ev;
         logic [1:0] o;
         ev = (c != 0) && (c % 5 != 0);
         o  = 2'(((c - 1) / 5) % 4);
         #1;
         check_out("sat", c, ev, ev ? o : 2'd0, ev ? (4'b0001 << o) : 4'b0000, 8'hA0 + 8'(o));
         if (c == 21) chk("sat.count20", 32'(fq.size()), 32'd16);
         cyc();
      end

      // Full stall after the second beat
      do_reset();
      sent = 0;
      for (int c = 0; c < 9; c++) begin
         logic ea, ev;
         ea = c == 1 || c == 2 || c == 6 || c == 7;
         ev = (c >= 1 && c <= 7);
         req = (sent < 4) ? 4'b0001 : 4'b0000;
         fifo_full = (c >= 3 && c <= 5);
         din[7:0] = 8'h30 + 8'(sent);
         #1;
         check_out("stall", c, ev, 2'd0, ea ? 4'b0001 : 4'b0000, 8'h30 + 8'(sent));
         if (ea) sent++;
         cyc();
      end
      fifo_full = 1'b0;
      chk("stall.count", 32'(fq.size()), 32'd4);

      // Early release: requester 2 drops after two acks, requester 3 waits
      do_reset();
      sent2 = 0;
      din[31:24] = 8'h77;
      for (int c = 0; c < 6; c++) begin
         logic [3:0] ea;
         logic       ev;
         logic [1:0] eid;
         req = (c <= 2) ? 4'b1100 : 4'b1000;
         din[23:16] = 8'h40 + 8'(sent2);
         ea  = (c == 1 || c == 2) ? 4'b0100 : (c == 5) ? 4'b1000 : 4'b0000;
         ev  = (c >= 1 && c <= 3) || c == 5;
         eid = (c >= 1 && c <= 3) ? 2'd2 : (c == 5) ? 2'd3 : 2'd0;
         #1;
         check_out("early", c, ev, eid, ea, (c == 5) ? 8'h77 : 8'h40 + 8'(sent2));
         if (c == 4) chk("early.beat_cnt", 32'(dut.beat_cnt_r), 32'd2);
         if (ea == 4'b0100) sent2++;
         cyc();
      end

      // Reset during requester 1's third beat
      do_reset();
      req = 4'b1111;
      din = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      for (int c = 0; c < 11; c++) begin
         logic       ev;
         logic [1:0] o;
         rst = (c == 8);
         ev  = (c >= 1 && c <= 4) || (c >= 6 && c <= 8) || c == 10;
         o   = (c >= 6 && c <= 8) ? 2'd1 : 2'd0;
         #1;
         check_out("rstmid", c, ev, o, ev ? (4'b0001 << o) : 4'b0000, 8'hA0 + 8'(o));
         if (c == 9) chk("rstmid.din", 32'(fifo_din), 32'd0);
         cyc();
      end
      rst = 1'b0;

      // Full already high when requester 0 is granted
      do_reset();
      req = 4'b0001;
      din[7:0] = 8'h5A;
      for (int c = 0; c < 4; c++) begin
         fifo_full = (c <= 2);
         #1;
         check_out("fullgrant", c, c >= 1, 2'd0, (c == 3) ? 4'b0001 : 4'b0000, 8'h5A);
         cyc();
      end
      chk("fullgrant.count", 32'(fq.size()), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
